// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB responder constants and state encoding
package sccb_pkg;

  localparam logic [7:0] SCCB_DEFAULT_SID = 8'h60;

  localparam int                   BIT_CNT_W    = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 4'd8;

  typedef logic [2:0] sccb_state_t;

  localparam sccb_state_t ST_IDLE      = 3'd0;
  localparam sccb_state_t ST_ID        = 3'd1;
  localparam sccb_state_t ST_ADDR      = 3'd2;
  localparam sccb_state_t ST_WDATA     = 3'd3;
  localparam sccb_state_t ST_RDATA     = 3'd4;
  localparam sccb_state_t ST_WAIT_STOP = 3'd5;

endpackage

// File: rtl/sccb_responder_if.sv
// rtl/sccb_responder_if.sv - register-file port between the SCCB responder and its register model
interface sccb_responder_if;
  import sccb_pkg::*;

  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re, busy,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re, busy,
    output reg_rdata
  );

endinterface

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - sioc/siod synchronizers with edge and start/stop pulses
// Shared with the bus monitor; pulses are combinational from the synchronized pair.
module sccb_line_sync
  import sccb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sioc_i,
  input  logic siod_i,
  output logic sioc_rise_o,
  output logic sioc_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic siod_o
);

  logic [2:0] sioc_pipe_q, sioc_pipe_d;
  logic [2:0] siod_pipe_q, siod_pipe_d;

  always_comb begin
    sioc_pipe_d = {sioc_pipe_q[1:0], sioc_i};
    siod_pipe_d = {siod_pipe_q[1:0], siod_i};
  end

  // Reset to the idle-high bus level so release of rst never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sioc_pipe_q <= 3'b111;
      siod_pipe_q <= 3'b111;
    end else begin
      sioc_pipe_q <= sioc_pipe_d;
      siod_pipe_q <= siod_pipe_d;
    end
  end

  assign siod_o      = siod_pipe_q[1];
  assign sioc_rise_o = sioc_pipe_q[1] & ~sioc_pipe_q[2];
  assign sioc_fall_o = ~sioc_pipe_q[1] & sioc_pipe_q[2];
  assign start_o     = sioc_pipe_q[1] & sioc_pipe_q[2] & ~siod_pipe_q[1] & siod_pipe_q[2];
  assign stop_o      = sioc_pipe_q[1] & sioc_pipe_q[2] & siod_pipe_q[1] & ~siod_pipe_q[2];

endmodule

// File: rtl/sccb_responder.sv
// rtl/sccb_responder.sv - SCCB target decoding 3-phase writes and 2-phase reads into a register port
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] SID        = SCCB_DEFAULT_SID,
  parameter bit         ACK_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sioc,
  inout  wire              siod,
  sccb_responder_if.master reg_if
);

  logic sioc_rise, sioc_fall, bus_start, bus_stop, siod_s;

  sccb_line_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .sioc_i      (sioc),
    .siod_i      (siod),
    .sioc_rise_o (sioc_rise),
    .sioc_fall_o (sioc_fall),
    .start_o     (bus_start),
    .stop_o      (bus_stop),
    .siod_o      (siod_s)
  );

  sccb_state_t          state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 we_q, we_d, re_q, re_d, load_q, load_d;
  logic                 oe_q, oe_d, ack_q, ack_d;
  logic                 wr_done_q, wr_done_d, busy_q, busy_d;

  logic [7:0] byte_in;
  logic       id_match, active;

  assign byte_in  = {shift_q[6:0], siod_s};
  assign id_match = (byte_in[7:1] == SID[7:1]);
  assign active   = (state_q != ST_IDLE) && (state_q != ST_WAIT_STOP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    load_d    = re_q;
    oe_d      = oe_q;
    ack_d     = ack_q;
    wr_done_d = wr_done_q;
    busy_d    = busy_q;

    // Register-file data arrives the cycle after reg_re, long before the first driven bit.
    if (load_q) shift_d = reg_if.reg_rdata;

    if (bus_stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (bus_start) begin
      state_d   = ST_ID;
      cnt_d     = '0;
      shift_d   = '0;
      oe_d      = 1'b0;
      ack_d     = 1'b0;
      wr_done_d = 1'b0;
      busy_d    = 1'b0;
    end else if (active && sioc_rise) begin
      if (cnt_q == BIT_CNT_LAST) begin
        cnt_d = '0;
        // The rise ending the master's NA slot closes the read.
        if (state_q == ST_RDATA && !ack_q) state_d = ST_WAIT_STOP;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        shift_d = (state_q == ST_RDATA) ? {shift_q[6:0], 1'b1} : byte_in;
        if (cnt_q == BIT_CNT_LAST - 4'd1) begin
          case (state_q)
            ST_ID: begin
              if (id_match) begin
                ack_d  = 1'b1;
                busy_d = 1'b1;
                if (byte_in[0]) begin
                  state_d = ST_RDATA;
                  re_d    = 1'b1;
                end else begin
                  state_d = ST_ADDR;
                end
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
            ST_ADDR: begin
              addr_d  = byte_in;
              ack_d   = 1'b1;
              state_d = ST_WDATA;
            end
            ST_WDATA: begin
              if (!wr_done_q) begin
                wdata_d   = byte_in;
                we_d      = 1'b1;
                ack_d     = 1'b1;
                wr_done_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
            default: ;
          endcase
        end
      end
    end else if (active && sioc_fall) begin
      if (cnt_q == BIT_CNT_LAST) begin
        oe_d = ack_q & ACK_ENABLE;
      end else begin
        ack_d = 1'b0;
        oe_d  = (state_q == ST_RDATA) ? ~shift_q[7] : 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      load_q    <= 1'b0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      load_q    <= load_d;
      oe_q      <= oe_d;
      ack_q     <= ack_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
    end
  end

  assign siod             = oe_q ? 1'b0 : 1'bz;
  assign reg_if.reg_addr  = addr_q;
  assign reg_if.reg_wdata = wdata_q;
  assign reg_if.reg_we    = we_q;
  assign reg_if.reg_re    = re_q;
  assign reg_if.busy      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// tb/tb_sccb_responder.sv - randomized scoreboard bench for sccb_responder
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam logic [7:0] SID_TB = 8'h60;
  localparam int Q_SLOW = 125;
  localparam int Q_FAST = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sioc = 1'b1;
  logic m_sda = 1'b1;
  wire  siod;

  pullup (siod);
  assign siod = m_sda ? 1'bz : 1'b0;

  sccb_responder_if rif ();

  sccb_responder #(.SID(SID_TB), .ACK_ENABLE(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .sioc   (sioc),
    .siod   (siod),
    .reg_if (rif.master)
  );

  initial forever #10 clk = ~clk;

  typedef struct packed {
    logic       is_write;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [7:0] rd_q;
  int         n_checks = 0;
  int         n_fail = 0;
  int         q = Q_FAST;

  // Register file: one-cycle read latency
  always @(posedge clk) if (rif.reg_re) rd_q <= model_mem[rif.reg_addr];
  assign rif.reg_rdata = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (rif.reg_we || rif.reg_re)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: we=%0b re=%0b addr=0x%0h, required no strobe",
                 rif.reg_we, rif.reg_re, rif.reg_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_is_write", {31'd0, rif.reg_we}, {31'd0, mon_e.is_write});
        check("strobe_re", {31'd0, rif.reg_re}, {31'd0, !mon_e.is_write});
        check("strobe_addr", {24'd0, rif.reg_addr}, {24'd0, mon_e.addr});
        if (mon_e.is_write) check("strobe_wdata", {24'd0, rif.reg_wdata}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; wclk(q);
    sioc  = 1'b1; wclk(q);
    m_sda = 1'b0; wclk(q);
    sioc  = 1'b0; wclk(q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wclk(q);
    sioc  = 1'b1; wclk(q);
    m_sda = 1'b1; wclk(q);
  endtask

  task automatic m_bit_out(input logic b);
    m_sda = b; wclk(q);
    sioc  = 1'b1; wclk(2 * q);
    sioc  = 1'b0; wclk(q);
  endtask

  task automatic m_bit_in(output logic b);
    m_sda = 1'b1; wclk(q);
    sioc  = 1'b1; wclk(q);
    b = siod; wclk(q);
    sioc  = 1'b0; wclk(q);
  endtask

  task automatic m_write_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) m_bit_out(d[i]);
    m_bit_in(a);
    check(name, {31'd0, a}, {31'd0, !exp_ack});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, rif.busy}, 32'd0);
    check({tag, "_reg_addr"}, {24'd0, rif.reg_addr}, {24'd0, model_ptr});
  endtask

  // Model: matched write ID acks ID, pointer byte and one data byte; anything further is ignored.
  task automatic txn_write(input logic [7:0] id, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n);
    logic [7:0] bytes [3];
    logic       match, ack;
    ev_t        e;
    bytes = '{b0, b1, b2};
    match = (id[7:1] == SID_TB[7:1]) && !id[0];
    m_start();
    m_write_byte(id, match, "id_ack");
    check("busy_after_id", {31'd0, rif.busy}, {31'd0, match});
    for (int i = 0; i < n; i++) begin
      ack = match && (i < 2);
      if (match && i == 0) model_ptr = bytes[0];
      if (match && i == 1) begin
        e.is_write = 1'b1;
        e.addr     = model_ptr;
        e.data     = bytes[1];
        exp_q.push_back(e);
        model_mem[model_ptr] = bytes[1];
      end
      m_write_byte(bytes[i], ack, "data_ack");
    end
    m_stop();
    check_idle_outputs("after_write");
  endtask

  task automatic txn_read(input int abort_bit);
    logic [7:0] exp_d, got;
    logic       b;
    ev_t        e;
    exp_d      = model_mem[model_ptr];
    got        = '0;
    e.is_write = 1'b0;
    e.addr     = model_ptr;
    e.data     = exp_d;
    exp_q.push_back(e);
    m_start();
    m_write_byte(SID_TB | 8'h01, 1'b1, "rd_id_ack");
    check("busy_in_read", {31'd0, rif.busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        m_sda = 1'b1; wclk(q);
        check("rd_bit_before_rst", {31'd0, siod}, {31'd0, exp_d[7-i]});
        #3 rst = 1'b1;
        #1 check("rst_releases_siod", {31'd0, siod}, 32'd1);
        sioc = 1'b1;
        wclk(2);
        check("rst_reg_addr", {24'd0, rif.reg_addr}, 32'd0);
        check("rst_reg_wdata", {24'd0, rif.reg_wdata}, 32'd0);
        check("rst_reg_we", {31'd0, rif.reg_we}, 32'd0);
        check("rst_reg_re", {31'd0, rif.reg_re}, 32'd0);
        check("rst_busy", {31'd0, rif.busy}, 32'd0);
        rst = 1'b0;
        model_ptr = 8'h00;
        wclk(q);
        return;
      end
      m_bit_in(b);
      got[7-i] = b;
    end
    check("read_data", {24'd0, got}, {24'd0, exp_d});
    m_bit_in(b);
    check("na_released", {31'd0, b}, 32'd1);
    m_stop();
    check_idle_outputs("after_read");
  endtask

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation ran past 90000 clk cycles");
    $fatal(1);
  end

  initial begin
    int         kind;
    logic [7:0] ra, rd, id;
    logic       b;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
    model_ptr = 8'h00;
    wclk(5);
    check("reset_siod", {31'd0, siod}, 32'd1);
    check("reset_reg_we", {31'd0, rif.reg_we}, 32'd0);
    check("reset_reg_re", {31'd0, rif.reg_re}, 32'd0);
    check("reset_reg_wdata", {24'd0, rif.reg_wdata}, 32'd0);
    check_idle_outputs("reset");
    rst = 1'b0;
    wclk(5);

    q = Q_SLOW;
    txn_write(8'h60, 8'hFF, 8'h01, 8'h00, 2);
    q = Q_FAST;

    model_mem[8'h0A] = 8'h26;
    txn_write(8'h60, 8'h0A, 8'h00, 8'h00, 1);
    txn_read(-1);

    txn_write(8'h42, 8'($urandom), 8'($urandom), 8'h00, 2);

    txn_write(8'h60, 8'h12, 8'h00, 8'h00, 1);
    txn_read(-1);

    // Partial data byte cut short by a repeated start
    m_start();
    m_write_byte(8'h60, 1'b1, "rs_id_ack");
    model_ptr = 8'h77;
    m_write_byte(8'h77, 1'b1, "rs_addr_ack");
    for (int i = 0; i < 4; i++) m_bit_out(1'b1);
    txn_write(8'h60, 8'h3D, 8'h55, 8'h00, 2);

    model_mem[8'h33] = 8'h5A;
    txn_write(8'h60, 8'h33, 8'h00, 8'h00, 1);
    txn_read(2);
    txn_write(8'h60, 8'($urandom), 8'($urandom), 8'h00, 2);
    txn_read(-1);

    for (int it = 0; it < 16; it++) begin
      kind = int'($urandom_range(0, 4));
      ra   = 8'($urandom);
      rd   = 8'($urandom);
      case (kind)
        0: txn_write(SID_TB, ra, rd, 8'h00, 2);
        1: txn_write(SID_TB, ra, 8'h00, 8'h00, 1);
        2: txn_read(-1);
        3: begin
          id = 8'($urandom);
          if (id[7:1] == SID_TB[7:1]) id = id ^ 8'h80;
          txn_write(id, ra, rd, 8'h00, 2);
        end
        default: txn_write(SID_TB, ra, rd, 8'($urandom), 3);
      endcase
    end

    wclk(10);
    b = 1'b0;
    check("events_outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
